// File: rtl/spw_pkg.sv
// Shared definitions for the SpaceWire transmit scheduler.
// Holds encoder character types, FSM states and credit constants.
package spw_pkg;

    localparam int MAX_CREDIT = 56;
    localparam int FCT_CREDIT = 8;

    typedef enum logic [1:0] {
        ENC_NONE  = 2'd0,
        ENC_FCT   = 2'd1,
        ENC_NCHAR = 2'd2,
        ENC_TIME  = 2'd3
    } enc_type_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/spw_credit_counter.sv
// Credit counter: add FCT_CREDIT with ceiling check, subtract 1 with
// underflow check. Ports: clock, reset (async low), clear (sync flush),
// add, sub, count, error (one-cycle pulse on rejected add/sub).
module spw_credit_counter #(
    parameter int WIDTH = 6,
    parameter int CEIL  = 56
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             add,
    input  logic             sub,
    output logic [WIDTH-1:0] count,
    output logic             error
);
    import spw_pkg::*;

    logic             add_ok;
    logic             sub_bad;
    logic [WIDTH-1:0] count_next;
    logic             error_next;

    // A simultaneous accepted add covers a subtract from zero (+7 net).
    always_comb begin
        add_ok     = add && (count <= WIDTH'(CEIL - FCT_CREDIT));
        sub_bad    = sub && (count == '0) && !add_ok;
        count_next = count;
        if (add_ok) begin
            count_next = count_next + WIDTH'(FCT_CREDIT);
        end
        if (sub && !sub_bad) begin
            count_next = count_next - WIDTH'(1);
        end
        error_next = (add && !add_ok) || sub_bad;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
            error <= 1'b0;
        end else if (clear) begin
            count <= '0;
            error <= 1'b0;
        end else begin
            count <= count_next;
            error <= error_next;
        end
    end

endmodule

// File: rtl/spw_tx_scheduler.sv
// SpaceWire TX scheduler: arbitrates time-codes, FCTs and N-chars onto
// the encoder with a valid/ready hold, and owns TX/RX credit counters.
// Ports: host write (txwrite/txdata/txready), tick_in/time_in, fct_rx,
// rx_open_slot, rx_nchar, encoder (enc_*), credits and error pulses.
module spw_tx_scheduler #(
    parameter int DWIDTH     = 9,
    parameter int CWIDTH     = 6,
    parameter int MAX_CREDIT = 56,
    parameter int PEND_MAX   = 7
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              link_run,
    input  logic              tick_in,
    input  logic [7:0]        time_in,
    input  logic              txwrite,
    input  logic [DWIDTH-1:0] txdata,
    output logic              txready,
    input  logic              fct_rx,
    input  logic              rx_open_slot,
    input  logic              rx_nchar,
    output logic              enc_valid,
    input  logic              enc_ready,
    output logic [1:0]        enc_type,
    output logic [DWIDTH-1:0] enc_data,
    output logic [CWIDTH-1:0] tx_credit,
    output logic [CWIDTH-1:0] rx_credit,
    output logic              tx_credit_error,
    output logic              rx_credit_error
);
    import spw_pkg::*;

    localparam int PW = $clog2(PEND_MAX + 1);

    state_t            state, state_next;
    enc_type_t         sel, type_q;
    logic [DWIDTH-1:0] data_q;
    logic              hold_full;
    logic [DWIDTH-1:0] hold_data;
    logic              tick_pend;
    logic [7:0]        time_q;
    logic [PW-1:0]     pend_fct;
    logic              slot_q;
    logic              slot_rise;
    logic              done;
    logic              fct_done;
    logic              nchar_done;
    logic              time_done;

    assign slot_rise  = rx_open_slot && !slot_q;
    assign done       = (state == S_HOLD) && enc_ready && link_run;
    assign fct_done   = done && (type_q == ENC_FCT);
    assign nchar_done = done && (type_q == ENC_NCHAR);
    assign time_done  = done && (type_q == ENC_TIME);

    // Source selection and next state
    always_comb begin
        sel = ENC_NONE;
        if (tick_pend) begin
            sel = ENC_TIME;
        end else if (pend_fct != '0 &&
                     rx_credit <= CWIDTH'(MAX_CREDIT - FCT_CREDIT)) begin
            sel = ENC_FCT;
        end else if (hold_full && tx_credit != '0) begin
            sel = ENC_NCHAR;
        end
        state_next = state;
        unique case (state)
            S_IDLE: if (sel != ENC_NONE) state_next = S_HOLD;
            S_HOLD: if (enc_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (!link_run) begin
            state_next = S_IDLE;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_next;
    end

    // Outputs
    assign enc_valid = (state == S_HOLD);
    assign enc_type  = type_q;
    assign enc_data  = data_q;
    assign txready   = !hold_full;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            type_q <= ENC_NONE;
            data_q <= '0;
        end else if (!link_run || done) begin
            type_q <= ENC_NONE;
        end else if (state == S_IDLE && sel != ENC_NONE) begin
            type_q <= sel;
            unique case (sel)
                ENC_TIME:  data_q <= DWIDTH'(time_q);
                ENC_NCHAR: data_q <= hold_data;
                default:   data_q <= '0;
            endcase
        end
    end

    // Input capture
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hold_full <= 1'b0;
            hold_data <= '0;
            tick_pend <= 1'b0;
            time_q    <= '0;
            pend_fct  <= '0;
            slot_q    <= 1'b0;
        end else begin
            slot_q <= rx_open_slot;
            if (txwrite && !hold_full) begin
                hold_full <= 1'b1;
                hold_data <= txdata;
            end else if (nchar_done) begin
                hold_full <= 1'b0;
            end
            if (tick_in) begin
                time_q <= time_in;
            end
            if (!link_run) begin
                tick_pend <= 1'b0;
                pend_fct  <= '0;
            end else begin
                if (tick_in)        tick_pend <= 1'b1;
                else if (time_done) tick_pend <= 1'b0;
                // Coincident edge and FCT completion cancel out
                if (slot_rise && !fct_done) begin
                    if (pend_fct != PW'(PEND_MAX)) begin
                        pend_fct <= pend_fct + PW'(1);
                    end
                end else if (fct_done && !slot_rise) begin
                    pend_fct <= pend_fct - PW'(1);
                end
            end
        end
    end

    spw_credit_counter #(
        .WIDTH (CWIDTH),
        .CEIL  (MAX_CREDIT)
    ) u_tx_credit (
        .clock (clock),
        .reset (reset),
        .clear (!link_run),
        .add   (fct_rx),
        .sub   (nchar_done),
        .count (tx_credit),
        .error (tx_credit_error)
    );

    spw_credit_counter #(
        .WIDTH (CWIDTH),
        .CEIL  (MAX_CREDIT)
    ) u_rx_credit (
        .clock (clock),
        .reset (reset),
        .clear (!link_run),
        .add   (fct_done),
        .sub   (rx_nchar),
        .count (rx_credit),
        .error (rx_credit_error)
    );

endmodule

// File: tb/tb_spw_tx_scheduler.sv
// Directed bench for spw_tx_scheduler: scheduling order, credit limits,
// hold stability, flush and reset behaviour against hand-computed values.
module tb_spw_tx_scheduler;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       link_run = 1'b0;
    logic       tick_in = 1'b0;
    logic [7:0] time_in = '0;
    logic       txwrite = 1'b0;
    logic [8:0] txdata = '0;
    logic       txready;
    logic       fct_rx = 1'b0;
    logic       rx_open_slot = 1'b0;
    logic       rx_nchar = 1'b0;
    logic       enc_valid;
    logic       enc_ready = 1'b0;
    logic [1:0] enc_type;
    logic [8:0] enc_data;
    logic [5:0] tx_credit;
    logic [5:0] rx_credit;
    logic       tx_credit_error;
    logic       rx_credit_error;

    int total = 0;
    int bad = 0;

    spw_tx_scheduler dut (
        .clock           (clock),
        .reset           (reset),
        .link_run        (link_run),
        .tick_in         (tick_in),
        .time_in         (time_in),
        .txwrite         (txwrite),
        .txdata          (txdata),
        .txready         (txready),
        .fct_rx          (fct_rx),
        .rx_open_slot    (rx_open_slot),
        .rx_nchar        (rx_nchar),
        .enc_valid       (enc_valid),
        .enc_ready       (enc_ready),
        .enc_type        (enc_type),
        .enc_data        (enc_data),
        .tx_credit       (tx_credit),
        .rx_credit       (rx_credit),
        .tx_credit_error (tx_credit_error),
        .rx_credit_error (rx_credit_error)
    );

    always #5 clock = ~clock;

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        #12;
        total++; if (enc_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b exp=0", enc_valid); end
        total++; if (enc_type !== 2'd0) begin bad++; $display("FAIL rst_type got=%0d exp=0", enc_type); end
        total++; if (txready !== 1'b1) begin bad++; $display("FAIL rst_txready got=%0b exp=1", txready); end
        total++; if (tx_credit !== 6'd0 || rx_credit !== 6'd0) begin bad++; $display("FAIL rst_credit got=%0d/%0d exp=0/0", tx_credit, rx_credit); end
        total++; if (tx_credit_error !== 1'b0 || rx_credit_error !== 1'b0) begin bad++; $display("FAIL rst_err got=%0b%0b exp=00", tx_credit_error, rx_credit_error); end
        cyc();
        reset = 1'b1;
        link_run = 1'b1;
        cyc();
    endtask

    task automatic test_nchar_credit();
        txwrite = 1'b1; txdata = 9'h0A5;
        cyc();
        txwrite = 1'b0;
        total++; if (txready !== 1'b0) begin bad++; $display("FAIL nc_txready_low got=%0b exp=0", txready); end
        cyc(); cyc(); cyc();
        total++; if (enc_valid !== 1'b0) begin bad++; $display("FAIL nc_no_credit got=%0b exp=0", enc_valid); end
        fct_rx = 1'b1;
        cyc();
        fct_rx = 1'b0;
        total++; if (tx_credit !== 6'd8) begin bad++; $display("FAIL nc_credit8 got=%0d exp=8", tx_credit); end
        cyc();
        total++; if (enc_valid !== 1'b1 || enc_type !== 2'd2 || enc_data !== 9'h0A5) begin bad++; $display("FAIL nc_offer got=%0b/%0d/%h exp=1/2/0a5", enc_valid, enc_type, enc_data); end
        enc_ready = 1'b1;
        cyc();
        enc_ready = 1'b0;
        total++; if (enc_valid !== 1'b0 || enc_type !== 2'd0) begin bad++; $display("FAIL nc_bubble got=%0b/%0d exp=0/0", enc_valid, enc_type); end
        total++; if (tx_credit !== 6'd7 || txready !== 1'b1) begin bad++; $display("FAIL nc_after got=%0d/%0b exp=7/1", tx_credit, txready); end
    endtask

    task automatic test_tx_ceiling();
        link_run = 1'b0;
        cyc();
        link_run = 1'b1;
        total++; if (tx_credit !== 6'd0) begin bad++; $display("FAIL ceil_flush got=%0d exp=0", tx_credit); end
        fct_rx = 1'b1;
        for (int i = 0; i < 7; i++) cyc();
        total++; if (tx_credit !== 6'd56 || tx_credit_error !== 1'b0) begin bad++; $display("FAIL ceil_56 got=%0d/%0b exp=56/0", tx_credit, tx_credit_error); end
        cyc();
        fct_rx = 1'b0;
        total++; if (tx_credit !== 6'd56 || tx_credit_error !== 1'b1) begin bad++; $display("FAIL ceil_err got=%0d/%0b exp=56/1", tx_credit, tx_credit_error); end
        cyc();
        total++; if (tx_credit_error !== 1'b0) begin bad++; $display("FAIL ceil_pulse got=%0b exp=0", tx_credit_error); end
    endtask

    task automatic test_priority();
        txwrite = 1'b1; txdata = 9'h155;
        tick_in = 1'b1; time_in = 8'h3C;
        rx_open_slot = 1'b1;
        cyc();
        txwrite = 1'b0; tick_in = 1'b0; rx_open_slot = 1'b0;
        total++; if (enc_valid !== 1'b0) begin bad++; $display("FAIL pri_idle got=%0b exp=0", enc_valid); end
        cyc();
        total++; if (enc_type !== 2'd3 || enc_data !== 9'h03C) begin bad++; $display("FAIL pri_time got=%0d/%h exp=3/03c", enc_type, enc_data); end
        cyc(); cyc();
        total++; if (enc_valid !== 1'b1 || enc_type !== 2'd3) begin bad++; $display("FAIL pri_time_hold got=%0b/%0d exp=1/3", enc_valid, enc_type); end
        enc_ready = 1'b1; cyc(); enc_ready = 1'b0;
        cyc();
        total++; if (enc_valid !== 1'b1 || enc_type !== 2'd1) begin bad++; $display("FAIL pri_fct got=%0b/%0d exp=1/1", enc_valid, enc_type); end
        enc_ready = 1'b1; cyc(); enc_ready = 1'b0;
        total++; if (rx_credit !== 6'd8) begin bad++; $display("FAIL pri_rx8 got=%0d exp=8", rx_credit); end
        cyc();
        total++; if (enc_type !== 2'd2 || enc_data !== 9'h155) begin bad++; $display("FAIL pri_nchar got=%0d/%h exp=2/155", enc_type, enc_data); end
        enc_ready = 1'b1; cyc(); enc_ready = 1'b0;
        total++; if (tx_credit !== 6'd55 || txready !== 1'b1) begin bad++; $display("FAIL pri_after got=%0d/%0b exp=55/1", tx_credit, txready); end
    endtask

    task automatic test_pend_sat();
        int fcts;
        link_run = 1'b0; cyc(); link_run = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rx_open_slot = 1'b1; cyc();
            rx_open_slot = 1'b0; cyc();
        end
        fcts = 0;
        enc_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (enc_valid && enc_type == 2'd1) fcts++;
            cyc();
        end
        enc_ready = 1'b0;
        total++; if (fcts != 7) begin bad++; $display("FAIL sat_fcts got=%0d exp=7", fcts); end
        total++; if (rx_credit !== 6'd56 || enc_valid !== 1'b0) begin bad++; $display("FAIL sat_rx56 got=%0d/%0b exp=56/0", rx_credit, enc_valid); end
        rx_open_slot = 1'b1; cyc(); rx_open_slot = 1'b0;
        cyc(); cyc(); cyc();
        total++; if (enc_valid !== 1'b0) begin bad++; $display("FAIL sat_blocked got=%0b exp=0", enc_valid); end
        rx_nchar = 1'b1;
        for (int i = 0; i < 8; i++) cyc();
        rx_nchar = 1'b0;
        total++; if (rx_credit !== 6'd48) begin bad++; $display("FAIL sat_rx48 got=%0d exp=48", rx_credit); end
        cyc();
        total++; if (enc_valid !== 1'b1 || enc_type !== 2'd1) begin bad++; $display("FAIL sat_resume got=%0b/%0d exp=1/1", enc_valid, enc_type); end
        enc_ready = 1'b1; cyc(); enc_ready = 1'b0;
        total++; if (rx_credit !== 6'd56) begin bad++; $display("FAIL sat_rx56b got=%0d exp=56", rx_credit); end
    endtask

    task automatic test_hold_flush();
        tick_in = 1'b1; time_in = 8'hA7;
        cyc();
        tick_in = 1'b0;
        cyc();
        txwrite = 1'b1; txdata = 9'h1C3;
        for (int i = 0; i < 5; i++) begin
            total++; if (enc_valid !== 1'b1 || enc_type !== 2'd3 || enc_data !== 9'h0A7) begin bad++; $display("FAIL hold_stable%0d got=%0b/%0d/%h exp=1/3/0a7", i, enc_valid, enc_type, enc_data); end
            cyc();
            txwrite = 1'b0;
        end
        link_run = 1'b0;
        cyc();
        total++; if (enc_valid !== 1'b0 || tx_credit !== 6'd0 || rx_credit !== 6'd0) begin bad++; $display("FAIL flush got=%0b/%0d/%0d exp=0/0/0", enc_valid, tx_credit, rx_credit); end
        total++; if (txready !== 1'b0) begin bad++; $display("FAIL flush_hold got=%0b exp=0", txready); end
        link_run = 1'b1;
        fct_rx = 1'b1; cyc(); fct_rx = 1'b0;
        cyc();
        total++; if (enc_type !== 2'd2 || enc_data !== 9'h1C3) begin bad++; $display("FAIL flush_keep got=%0d/%h exp=2/1c3", enc_type, enc_data); end
        enc_ready = 1'b1; cyc(); enc_ready = 1'b0;
        total++; if (tx_credit !== 6'd7) begin bad++; $display("FAIL flush_tx7 got=%0d exp=7", tx_credit); end
    endtask

    task automatic test_rx_underflow();
        link_run = 1'b0; cyc(); link_run = 1'b1;
        rx_nchar = 1'b1; cyc(); rx_nchar = 1'b0;
        total++; if (rx_credit_error !== 1'b1 || rx_credit !== 6'd0) begin bad++; $display("FAIL uf_err got=%0b/%0d exp=1/0", rx_credit_error, rx_credit); end
        cyc();
        total++; if (rx_credit_error !== 1'b0) begin bad++; $display("FAIL uf_pulse got=%0b exp=0", rx_credit_error); end
    endtask

    task automatic test_reset_mid_hold();
        fct_rx = 1'b1; cyc(); fct_rx = 1'b0;
        tick_in = 1'b1; time_in = 8'h11; cyc(); tick_in = 1'b0;
        cyc();
        total++; if (enc_valid !== 1'b1 || tx_credit !== 6'd8) begin bad++; $display("FAIL rmh_pre got=%0b/%0d exp=1/8", enc_valid, tx_credit); end
        #2;
        reset = 1'b0;
        #1;
        total++; if (enc_valid !== 1'b0 || enc_type !== 2'd0 || enc_data !== 9'h000) begin bad++; $display("FAIL rmh_enc got=%0b/%0d/%h exp=0/0/000", enc_valid, enc_type, enc_data); end
        total++; if (txready !== 1'b1 || tx_credit !== 6'd0 || rx_credit !== 6'd0) begin bad++; $display("FAIL rmh_state got=%0b/%0d/%0d exp=1/0/0", txready, tx_credit, rx_credit); end
    endtask

    initial begin
        test_reset();
        test_nchar_credit();
        test_tx_ceiling();
        test_priority();
        test_pend_sat();
        test_hold_flush();
        test_rx_underflow();
        test_reset_mid_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
